// File: rtl/target_sequencer.sv
// Game sequencer: picks targets from the LFSR, debounces box strikes, judges hit/miss and runs the countdown.
// Define TARGET_MISS_PENALTY_EN to make every miss also take one point off the score (floor 0).
module target_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int WINDOW_MS    = 1500,
  parameter int GAME_SECONDS = 60
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start_game,
  input  logic [2:0]  lfsr_value,
  input  logic [2:0]  box_address,
  output logic [2:0]  mif_control_signal,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [10:0] score,
  output logic [6:0]  game_timer,
  output logic        game_over,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    LOBBY = 2'd0,
    PICK  = 2'd1,
    SHOW  = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] DEB_TICKS = 16'(DEBOUNCE_MS);
  localparam logic [15:0] WIN_TICKS = 16'(WINDOW_MS);
  localparam logic [6:0]  GAME_SEC  = 7'(GAME_SECONDS);
  localparam logic [9:0]  MS_LAST   = 10'd999;
  localparam logic [10:0] SCORE_MAX = 11'h7FF;

  state_e      state_q, state_d;
  logic [15:0] tick_cnt_q;
  logic        tick;
  logic [2:0]  sync1_q, sync2_q, cand_q, deb_box_q;
  logic [15:0] deb_cnt_q;
  logic        deb_load, strike;
  logic        start_prev_q, start_rise;
  logic [2:0]  target_q, target_d, pick_cand;
  logic [10:0] score_q, score_d;
  logic [6:0]  timer_q, timer_d;
  logic [9:0]  ms_cnt_q, ms_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic        hit_q, hit_d, miss_q, miss_d;
  logic        expired;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick ? '0 : tick_cnt_q + 16'd1;
  end

  // cand_q is the last synchronized value; it must survive DEB_TICKS ticks unchanged to be accepted.
  assign deb_load = (deb_cnt_q == DEB_TICKS) && (deb_box_q != cand_q);
  assign strike   = deb_load && (cand_q != 3'd0);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
      deb_box_q <= '0;
    end else begin
      sync1_q <= box_address;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q    <= sync2_q;
        deb_cnt_q <= '0;
      end else if (tick && (deb_cnt_q != DEB_TICKS)) begin
        deb_cnt_q <= deb_cnt_q + 16'd1;
      end
      if (deb_load) deb_box_q <= cand_q;
    end
  end

  // Resetting the edge detector high means a start_game held across reset never counts as an edge.
  assign start_rise = start_game && !start_prev_q;
  assign expired    = (timer_q == 7'd0);
  assign pick_cand  = (lfsr_value == 3'd0) ? 3'd1 : lfsr_value;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    score_d   = score_q;
    timer_d   = timer_q;
    ms_cnt_d  = ms_cnt_q;
    win_cnt_d = win_cnt_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    if (((state_q == PICK) || (state_q == SHOW)) && tick) begin
      if (ms_cnt_q == MS_LAST) begin
        ms_cnt_d = '0;
        if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
      end else begin
        ms_cnt_d = ms_cnt_q + 10'd1;
      end
    end
    case (state_q)
      LOBBY, OVER: begin
        if (start_rise) begin
          score_d  = '0;
          timer_d  = GAME_SEC;
          ms_cnt_d = '0;
          state_d  = PICK;
        end
      end
      PICK: begin
        if (expired) begin
          state_d = OVER;
        end else begin
          if (pick_cand == target_q) target_d = (target_q == 3'd7) ? 3'd1 : target_q + 3'd1;
          else                       target_d = pick_cand;
          win_cnt_d = '0;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (expired) begin
          state_d = OVER;
        end else if (strike && (cand_q == target_q)) begin
          hit_d   = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + 11'd1;
          state_d = PICK;
        end else if (strike || (win_cnt_q == WIN_TICKS)) begin
          miss_d  = 1'b1;
          state_d = PICK;
        end else if (tick) begin
          win_cnt_d = win_cnt_q + 16'd1;
        end
      end
      default: state_d = LOBBY;
    endcase
`ifdef TARGET_MISS_PENALTY_EN
    if (miss_d && (score_q != 11'd0)) score_d = score_q - 11'd1;
`else
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= LOBBY;
      start_prev_q <= 1'b1;
      target_q     <= '0;
      score_q      <= '0;
      timer_q      <= '0;
      ms_cnt_q     <= '0;
      win_cnt_q    <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_game;
      target_q     <= target_d;
      score_q      <= score_d;
      timer_q      <= timer_d;
      ms_cnt_q     <= ms_cnt_d;
      win_cnt_q    <= win_cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign mif_control_signal = (state_q == SHOW) ? target_q : 3'd0;
  assign hit_pulse          = hit_q;
  assign miss_pulse         = miss_q;
  assign score              = score_q;
  assign game_timer         = timer_q;
  assign game_over          = (state_q == OVER);
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_target_sequencer.sv
// Self-checking bench for target_sequencer with a transaction-level model of score and target choice.
module tb_target_sequencer;

  localparam int TICK_DIV     = 4;
  localparam int DEBOUNCE_MS  = 2;
  localparam int WINDOW_MS    = 10;
  localparam int GAME_SECONDS = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_game;
  logic [2:0]  lfsr_value;
  logic [2:0]  box_address;
  logic [2:0]  mif_control_signal;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [10:0] score;
  logic [6:0]  game_timer;
  logic        game_over;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int m_score;
  int m_target;
  int mon_hits;
  int mon_misses;

  target_sequencer #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEBOUNCE_MS),
    .WINDOW_MS(WINDOW_MS), .GAME_SECONDS(GAME_SECONDS)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_game),
    .lfsr_value(lfsr_value), .box_address(box_address),
    .mif_control_signal(mif_control_signal), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score(score), .game_timer(game_timer),
    .game_over(game_over), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  // Reference rules: target choice from LFSR/previous target, and the effect of a miss on the score.
  function automatic int next_target(input int lfsr, input int prev);
    int c;
    c = (lfsr == 0) ? 1 : lfsr;
    if (c == prev) return (prev % 7) + 1;
    return c;
  endfunction

  function automatic int after_miss(input int s);
`ifdef TARGET_MISS_PENALTY_EN
    return (s > 0) ? s - 1 : 0;
`else
    return s;
`endif
  endfunction

  function automatic int after_hit(input int s);
    return (s < 2047) ? s + 1 : s;
  endfunction

  task automatic wait_pulse(input int max_cycles, output bit got_hit, output bit got_miss, output int cycles);
    got_hit = 1'b0; got_miss = 1'b0; cycles = 0;
    while (!got_hit && !got_miss && (cycles < max_cycles)) begin
      @(negedge clk);
      cycles++;
      got_hit  = (hit_pulse === 1'b1);
      got_miss = (miss_pulse === 1'b1);
    end
  endtask

  // Applies any pulse seen this cycle to the model, given the LFSR value the following PICK will use.
  task automatic note_pulses(input int lfsr);
    if (hit_pulse === 1'b1) begin
      mon_hits++; m_score = after_hit(m_score); m_target = next_target(lfsr, m_target);
    end
    if (miss_pulse === 1'b1) begin
      mon_misses++; m_score = after_miss(m_score); m_target = next_target(lfsr, m_target);
    end
  endtask

  task automatic start_new_game(input int lfsr);
    resetn = 1'b0; start_game = 1'b0; box_address = 3'd0; lfsr_value = 3'(lfsr);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    @(negedge clk);
    m_score = 0;
    m_target = next_target(lfsr, 0);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_game = 1'b1; box_address = 3'd0; lfsr_value = 3'd3;
    repeat (3) @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'd0) begin n_fail++; $display("FAIL reset_mif: got %0d expected 0", mif_control_signal); end
    n_checks++; if (score !== 11'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_checks++; if (game_timer !== 7'd0) begin n_fail++; $display("FAIL reset_timer: got %0d expected 0", game_timer); end
    n_checks++; if ({hit_pulse, miss_pulse, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {hit_pulse, miss_pulse, game_over}); end
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL held_start_state: got %0d expected 0", dbg_state_o); end
    n_checks++; if (mif_control_signal !== 3'd0) begin n_fail++; $display("FAIL held_start_mif: got %0d expected 0", mif_control_signal); end
    n_checks++; if (score !== 11'd0) begin n_fail++; $display("FAIL held_start_score: got %0d expected 0", score); end
    start_game = 1'b0;
    @(negedge clk);
    start_game = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_state_o !== 2'd1) begin n_fail++; $display("FAIL start_pick: got %0d expected 1", dbg_state_o); end
    n_checks++; if (game_timer !== 7'(GAME_SECONDS)) begin n_fail++; $display("FAIL start_timer: got %0d expected %0d", game_timer, GAME_SECONDS); end
    start_game = 1'b0;
    @(negedge clk);
    m_target = next_target(3, 0);
    n_checks++; if (dbg_state_o !== 2'd2) begin n_fail++; $display("FAIL start_show: got %0d expected 2", dbg_state_o); end
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL start_target: got %0d expected %0d", mif_control_signal, m_target); end
  endtask

  task automatic test_hit();
    bit h, m; int c, extra;
    start_new_game(3);
    n_checks++; if (mif_control_signal !== 3'd3) begin n_fail++; $display("FAIL hit_target_shown: got %0d expected 3", mif_control_signal); end
    lfsr_value = 3'($urandom_range(0, 7));
    box_address = 3'd3;
    wait_pulse(40, h, m, c);
    n_checks++; if ({h, m} !== 2'b10) begin n_fail++; $display("FAIL hit_pulse_kind: got hit=%0d miss=%0d expected hit=1 miss=0", h, m); end
    m_score = after_hit(m_score);
    m_target = next_target(int'(lfsr_value), 3);
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL hit_score: got %0d expected %0d", score, m_score); end
    @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL hit_new_target: got %0d expected %0d", mif_control_signal, m_target); end
    extra = 0;
    repeat (28) begin @(negedge clk); if (hit_pulse === 1'b1 || miss_pulse === 1'b1) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL hit_held_single: got %0d extra pulses expected 0", extra); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_miss();
    bit h, m; int c;
    start_new_game(5);
    lfsr_value = 3'($urandom_range(0, 7));
    box_address = 3'd2;
    wait_pulse(40, h, m, c);
    n_checks++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL miss_pulse_kind: got hit=%0d miss=%0d expected hit=0 miss=1", h, m); end
    m_score = after_miss(m_score);
    m_target = next_target(int'(lfsr_value), 5);
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL miss_score_zero: got %0d expected %0d", score, m_score); end
    @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL miss_new_target: got %0d expected %0d", mif_control_signal, m_target); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
    box_address = 3'(m_target);
    wait_pulse(40, h, m, c);
    m_score = after_hit(m_score);
    m_target = next_target(int'(lfsr_value), m_target);
    n_checks++; if ({h, m, score} !== {2'b10, 11'(m_score)}) begin n_fail++; $display("FAIL miss_setup_hit: got hit=%0d miss=%0d score=%0d expected 1 0 %0d", h, m, score, m_score); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
    box_address = 3'((m_target % 7) + 1);
    wait_pulse(40, h, m, c);
    m_score = after_miss(m_score);
    n_checks++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL miss2_pulse_kind: got hit=%0d miss=%0d expected hit=0 miss=1", h, m); end
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL miss2_score: got %0d expected %0d", score, m_score); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit h, m; int c;
    start_new_game(1);
    lfsr_value = 3'd0;
    wait_pulse(60, h, m, c);
    n_checks++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL timeout_kind: got hit=%0d miss=%0d expected hit=0 miss=1", h, m); end
    n_checks++; if (c < 34 || c > 46) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 34..46", c); end
    m_score = after_miss(m_score);
    m_target = next_target(0, 1);
    @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL timeout_zero_lfsr_target: got %0d expected %0d", mif_control_signal, m_target); end
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL timeout_score: got %0d expected %0d", score, m_score); end
    lfsr_value = 3'd7;
    wait_pulse(60, h, m, c);
    m_target = next_target(7, m_target);
    @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL timeout2_target: got %0d expected %0d", mif_control_signal, m_target); end
  endtask

  task automatic test_debounce();
    bit h, m; int c, glitch_pulses;
    start_new_game(4);
    box_address = 3'd4;
    repeat (4) @(negedge clk);
    box_address = 3'd0;
    glitch_pulses = 0;
    repeat (10) begin @(negedge clk); if (hit_pulse === 1'b1 || miss_pulse === 1'b1) glitch_pulses++; end
    n_checks++; if (glitch_pulses != 0) begin n_fail++; $display("FAIL glitch_no_event: got %0d pulses expected 0", glitch_pulses); end
    lfsr_value = 3'd6;
    box_address = 3'd4;
    mon_hits = 0; mon_misses = 0;
    repeat (80) begin @(negedge clk); note_pulses(6); end
    do begin @(negedge clk); note_pulses(6); end while (hit_pulse === 1'b1 || miss_pulse === 1'b1);
    n_checks++; if (mon_hits != 1) begin n_fail++; $display("FAIL hold_single_hit: got %0d hits expected 1", mon_hits); end
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL hold_score: got %0d expected %0d", score, m_score); end
    lfsr_value = 3'd4;
    box_address = 3'd0;
    wait_pulse(60, h, m, c);
    m_score = after_miss(m_score);
    m_target = next_target(4, m_target);
    n_checks++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL retarget_kind: got hit=%0d miss=%0d expected hit=0 miss=1", h, m); end
    @(negedge clk);
    n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL retarget_four: got %0d expected %0d", mif_control_signal, m_target); end
    repeat (14) @(negedge clk);
    box_address = 3'd4;
    wait_pulse(40, h, m, c);
    m_score = after_hit(m_score);
    n_checks++; if ({h, m} !== 2'b10) begin n_fail++; $display("FAIL restrike_hit: got hit=%0d miss=%0d expected hit=1 miss=0", h, m); end
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL restrike_score: got %0d expected %0d", score, m_score); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_random_rounds();
    bit h, m, want_hit; int c;
    start_new_game(int'($urandom_range(0, 7)));
    for (int r = 0; r < 16; r++) begin
      lfsr_value = 3'($urandom_range(0, 7));
      want_hit = 1'($urandom_range(0, 1));
      if (want_hit) box_address = 3'(m_target);
      else          box_address = 3'(((m_target - 1 + int'($urandom_range(1, 6))) % 7) + 1);
      wait_pulse(40, h, m, c);
      if (want_hit) m_score = after_hit(m_score);
      else          m_score = after_miss(m_score);
      m_target = next_target(int'(lfsr_value), m_target);
      n_checks++; if ({h, m} !== {want_hit, !want_hit}) begin n_fail++; $display("FAIL rand_kind[%0d]: got hit=%0d miss=%0d expected hit=%0d", r, h, m, want_hit); end
      n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL rand_score[%0d]: got %0d expected %0d", r, score, m_score); end
      @(negedge clk);
      n_checks++; if (mif_control_signal !== 3'(m_target)) begin n_fail++; $display("FAIL rand_target[%0d]: got %0d expected %0d", r, mif_control_signal, m_target); end
      box_address = 3'd0;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_expiry();
    bit h, m; int c, elapsed, late_pulses;
    time t0;
    start_new_game(2);
    t0 = $time;
    lfsr_value = 3'd5;
    box_address = 3'd2;
    wait_pulse(40, h, m, c);
    mon_hits = 0; mon_misses = 0;
    m_score = after_hit(m_score);
    m_target = next_target(5, 2);
    box_address = 3'd0;
    elapsed = 0;
    while (game_over !== 1'b1 && elapsed < 8300) begin
      @(negedge clk);
      elapsed = int'(($time - t0) / 10);
      note_pulses(5);
      if (elapsed == 4500) begin
        n_checks++; if (game_timer !== 7'd1) begin n_fail++; $display("FAIL mid_game_timer: got %0d expected 1", game_timer); end
      end
    end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL expiry_reached: got game_over=%0d expected 1 within budget", game_over); end
    n_checks++; if (elapsed < 7990 || elapsed > 8010) begin n_fail++; $display("FAIL expiry_time: got %0d cycles expected 7990..8010", elapsed); end
    n_checks++; if (mon_hits != 0) begin n_fail++; $display("FAIL expiry_no_hits: got %0d expected 0", mon_hits); end
    n_checks++; if ({game_timer, mif_control_signal, dbg_state_o} !== {7'd0, 3'd0, 2'd3}) begin n_fail++; $display("FAIL over_outputs: got timer=%0d mif=%0d state=%0d expected 0 0 3", game_timer, mif_control_signal, dbg_state_o); end
    n_checks++; if (score !== 11'(m_score)) begin n_fail++; $display("FAIL over_score: got %0d expected %0d", score, m_score); end
    box_address = 3'(m_target);
    late_pulses = 0;
    repeat (30) begin @(negedge clk); if (hit_pulse === 1'b1 || miss_pulse === 1'b1) late_pulses++; end
    n_checks++; if (late_pulses != 0 || score !== 11'(m_score) || game_timer !== 7'd0) begin n_fail++; $display("FAIL over_strike_ignored: got pulses=%0d score=%0d timer=%0d expected 0 %0d 0", late_pulses, score, game_timer, m_score); end
    box_address = 3'd0;
    repeat (16) @(negedge clk);
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    n_checks++; if ({dbg_state_o, score, game_timer} !== {2'd1, 11'd0, 7'(GAME_SECONDS)}) begin n_fail++; $display("FAIL restart: got state=%0d score=%0d timer=%0d expected 1 0 %0d", dbg_state_o, score, game_timer, GAME_SECONDS); end
    @(negedge clk);
    m_target = next_target(5, m_target);
    n_checks++; if ({game_over, mif_control_signal} !== {1'b0, 3'(m_target)}) begin n_fail++; $display("FAIL restart_show: got over=%0d mif=%0d expected 0 %0d", game_over, mif_control_signal, m_target); end
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if ({mif_control_signal, score, game_timer, hit_pulse, miss_pulse, game_over, dbg_state_o} !== 26'd0) begin n_fail++; $display("FAIL midgame_reset: got mif=%0d score=%0d timer=%0d over=%0d state=%0d expected all 0", mif_control_signal, score, game_timer, game_over, dbg_state_o); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start_game = 1'b1; lfsr_value = 3'd0; box_address = 3'd0;
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_debounce();
    test_random_rounds();
    test_expiry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/target_sequencer.md
# target_sequencer

Game-sequencing stage directly upstream of the hit/score datapath: it picks the active target box from the LFSR value, drives `mif_control_signal` to select the VGA screen, and debounces the Arduino `box_address` bus. It also judges each strike as a hit or a miss against a per-target time window, and runs the game countdown. The score, hit/miss pulses and game-over flag it produces feed the datapath's audio and display logic.

## Interface
Parameters:
- `TICK_DIV`, 50000: `CLOCK_50` cycles per 1 ms tick (small values for simulation).
- `DEBOUNCE_MS`, 20: ticks the synchronized `box_address` must be stable before it is accepted.
- `WINDOW_MS`, 1500: ticks a target stays up before it counts as a miss.
- `GAME_SECONDS`, 60: game length in seconds (1000 ticks each); at most 127.

Ports:
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start_game`, in, 1: level input; only its rising edge acts.
- `lfsr_value`, in, 3: free-running random value.
- `box_address`, in, 3: raw Arduino box code, asynchronous to `CLOCK_50`; 0 means no box struck.
- `mif_control_signal`, out, 3: 0 selects the lobby/over screen; 1..7 is the active target box.
- `hit_pulse`, out, 1: one-cycle pulse on a correct strike.
- `miss_pulse`, out, 1: one-cycle pulse on a wrong strike or window timeout.
- `score`, out, 11: hit count.
- `game_timer`, out, 7: seconds remaining.
- `game_over`, out, 1: high in the OVER state.

## Operation
Input conditioning:
- `box_address` passes through a 2-FF synchronizer.
- A debounce counter restarts whenever the synchronized value changes.
- The debounced register `deb_box` loads the value once it has been stable for `DEBOUNCE_MS` ticks.
- A strike event is a cycle in which `deb_box` updates to a nonzero value.

States:
- LOBBY: `mif_control_signal` = 0. A `start_game` rising edge clears `score`, loads `game_timer` = `GAME_SECONDS`, and moves to PICK.
- PICK (one cycle): computes a candidate target and moves to SHOW.
  - Candidate = `lfsr_value`; a value of 0 maps to 1.
  - If the candidate equals the previous target, the target becomes (previous mod 7)+1.
  - The window counter is cleared.
- SHOW: `mif_control_signal` = target. Exactly one action is taken per cycle, in this priority order:
  - Timer expiry: go to OVER.
  - Strike with `deb_box` = target: `hit_pulse`, `score`+1 (saturates at 2047), go to PICK.
  - Strike with `deb_box` ≠ target: `miss_pulse`, go to PICK.
  - Window counter reaches `WINDOW_MS`: `miss_pulse`, go to PICK.
- OVER: `mif_control_signal` = 0, `game_over` = 1, and `score` is held. A `start_game` rising edge behaves as it does in LOBBY.

Countdown and start:
- The seconds counter runs only in PICK and SHOW.
- Every 1000 ticks, `game_timer` decrements.
- Reaching 0 raises expiry, which enters OVER at the next SHOW or PICK evaluation. PICK also checks expiry.
- A `start_game` edge in PICK or SHOW is ignored.

## Timing
Reset values:
- State = LOBBY.
- `mif_control_signal` = 0, `score` = 0, `game_timer` = 0.
- Pulses = 0, `game_over` = 0.
- `deb_box` = 0, previous target = 0.
- All counters = 0.

Latencies:
- `box_address` change → strike: 2 sync cycles + `DEBOUNCE_MS` ticks (± 1 tick quantization) + 1 cycle.
- Strike → `hit_pulse`/`miss_pulse` and `score` update: registered, in the same cycle as the state change to PICK.
- PICK → new `mif_control_signal` value: 1 cycle.

Boundary behaviour:
- A strike only fires when `deb_box` changes. Holding a box produces a single event, and a repeat hit on the same box requires a release to 0 first.
- Strikes that arrive in PICK are discarded.
- `resetn` low mid-game returns to LOBBY immediately and clears all outputs.

## Configuration
- `TARGET_MISS_PENALTY_EN` defined: every `miss_pulse` also decrements `score`, with a floor of 0 (score 0 stays 0).
- `TARGET_MISS_PENALTY_EN` undefined: misses never change `score`.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_MS`=2, `WINDOW_MS`=10, `GAME_SECONDS`=2.

- Reset → release, with `start_game` held high throughout → state stays LOBBY, `mif_control_signal`=0, `score`=0. Then pulse `start_game` → PICK then SHOW, `game_timer`=2.
- `lfsr_value`=3 at PICK; strike `box_address`=3 held past debounce → exactly one `hit_pulse`, `score`=1, new target ≠ 3.
- Target 5; strike box 2 → `miss_pulse`, `score` unchanged. Repeat with `TARGET_MISS_PENALTY_EN` defined at `score`=0 → `score` stays 0.
- No strikes for 10 ticks in SHOW → `miss_pulse`, new target. `lfsr_value`=0 with previous target 1 → target 2.
- `box_address` glitches for 1 tick → no event. Hold box 4 (the current target) for 20 ticks → one hit only. Release then re-strike on a later target 4 → another hit.
- Let 2000 ticks elapse → `game_timer` reaches 0, OVER, `game_over`=1, `score` held. A strike coinciding with expiry does not count. Pulse `start_game` → `score`=0. Assert `resetn`=0 mid-SHOW → all outputs at reset values.
